// File: rtl/fft_peak_scan.sv
// Finds the largest-magnitude bin of a 16-bin complex frame, one bin per cycle through a single squaring datapath.
// Latency: frame accepted in cycle t, result pulsed in t+17. A frame offered while busy is dropped and flagged.
module fft_peak_scan (
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        ready,
    output logic        peak_valid,
    output logic [3:0]  peak_idx,
    output logic [31:0] peak_mag,
    output logic        overrun,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_k;
    logic [31:0]        r_max;
    logic [3:0]         r_max_idx;
    logic [31:0]        r_bank [16];

    logic [31:0]        w_din [16];
    logic [31:0]        w_cur;
    logic signed [31:0] w_re;
    logic signed [31:0] w_im;
    logic signed [31:0] w_sq_re;
    logic signed [31:0] w_sq_im;
    logic [31:0]        w_mag;
    logic               w_take;
    logic [31:0]        w_new_max;
    logic [3:0]         w_new_idx;
    logic               w_accept;

    assign w_din[0]  = fft_d0;
    assign w_din[1]  = fft_d1;
    assign w_din[2]  = fft_d2;
    assign w_din[3]  = fft_d3;
    assign w_din[4]  = fft_d4;
    assign w_din[5]  = fft_d5;
    assign w_din[6]  = fft_d6;
    assign w_din[7]  = fft_d7;
    assign w_din[8]  = fft_d8;
    assign w_din[9]  = fft_d9;
    assign w_din[10] = fft_d10;
    assign w_din[11] = fft_d11;
    assign w_din[12] = fft_d12;
    assign w_din[13] = fft_d13;
    assign w_din[14] = fft_d14;
    assign w_din[15] = fft_d15;

    assign ready    = (r_state == S_IDLE);
    assign w_accept = ready && fft_valid;

    // Each square is at most 2^30, so 32-bit products and an unsigned 32-bit sum cannot overflow.
    assign w_cur     = r_bank[r_k];
    assign w_re      = {{16{w_cur[31]}}, w_cur[31:16]};
    assign w_im      = {{16{w_cur[15]}}, w_cur[15:0]};
    assign w_sq_re   = w_re * w_re;
    assign w_sq_im   = w_im * w_im;
    assign w_mag     = $unsigned(w_sq_re) + $unsigned(w_sq_im);
    assign w_take    = (r_k == 4'd0) || (w_mag > r_max);
    assign w_new_max = w_take ? w_mag : r_max;
    assign w_new_idx = w_take ? r_k : r_max_idx;

    // The bank only feeds the scan, which cannot start before it is loaded, so it needs no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_accept) begin
            for (int i = 0; i < 16; i++) begin
                r_bank[i] <= w_din[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_k        <= 4'd0;
            r_max      <= 32'd0;
            r_max_idx  <= 4'd0;
            peak_valid <= 1'b0;
            peak_idx   <= 4'd0;
            peak_mag   <= 32'd0;
            overrun    <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            overrun    <= fft_valid && (r_state != S_IDLE);
            peak_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fft_valid) begin
                        r_k     <= 4'd0;
                        r_state <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_max     <= w_new_max;
                    r_max_idx <= w_new_idx;
                    r_k       <= r_k + 4'd1;
                    // Last bin: publish straight from the compare so the result appears in the OUT cycle.
                    if (r_k == 4'd15) begin
                        r_state    <= S_OUT;
                        peak_valid <= 1'b1;
                        peak_idx   <= w_new_idx;
                        peak_mag   <= w_new_max;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end
                end
                S_OUT: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/fft_peak_scan.md
FFT_PEAK_SCAN -- requirements
Module: fft_peak_scan

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port fft_valid  input  1  one-cycle strobe: fft_d0..fft_d15 hold a complete 16-bin frame.
REQ-004 SHALL have ports fft_d0..fft_d15  input  32 each  bin k: [31:16] real, [15:0] imag, both two's-complement signed 16-bit.
REQ-005 SHALL have port ready  output  1  high when a frame can be accepted.
REQ-006 SHALL have port peak_valid  output  1  one-cycle pulse; peak_idx/peak_mag valid.
REQ-007 SHALL have port peak_idx  output  4  bin index of the largest magnitude.
REQ-008 SHALL have port peak_mag  output  32  unsigned real^2+imag^2 of the peak bin.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: fft_valid arrived while ready=0.
REQ-010 SHALL have port frame_cnt  output  8  count of completed frames, wraps 255->0.

Function
REQ-011 SHALL implement states IDLE, SCAN and OUT, with ready=1 only in IDLE.
REQ-012 IDLE: on fft_valid=1, SHALL register all 16 input words into an internal bank, clear bin counter k to 0, and go to SCAN.
REQ-013 IDLE with fft_valid=0: SHALL stay in IDLE.
REQ-014 SCAN: SHALL process one bin per cycle, k=0..15, using a single squaring datapath (one real and one imag square per cycle).
REQ-015 Magnitude: re^2+im^2 with signed 16x16 squares (each max 2^30), summed unsigned 32-bit without overflow; max value 0x8000_0000.
REQ-016 Bin 0: SHALL load as the running max unconditionally.
REQ-017 Bins 1..15: SHALL replace the running max only if strictly greater, so ties resolve to the lowest index.
REQ-018 After bin 15: SHALL go to OUT.
REQ-019 OUT: SHALL pulse peak_valid=1 for exactly one cycle, present peak_idx/peak_mag, increment frame_cnt, and return to IDLE.
REQ-020 Latency: fft_valid accepted in cycle t; SCAN occupies cycles t+1..t+16; peak_valid=1 in cycle t+17; ready=1 again in cycle t+18.
REQ-021 peak_idx and peak_mag SHALL hold their values until the next peak_valid.
REQ-022 fft_valid while ready=0 (SCAN or OUT): frame SHALL be ignored, overrun SHALL pulse in the next cycle, and the in-progress frame SHALL be unaffected.
REQ-023 Input changes on fft_d* after acceptance SHALL not affect the result (the bank is the sole source).
REQ-024 All-zero frame: SHALL report peak_idx=0, peak_mag=0.
REQ-025 All outputs SHALL be registered, except ready, which is decoded from state.

Reset
REQ-026 rst=1 at a clock edge SHALL force state to IDLE and set peak_valid=0, overrun=0, peak_idx=0, peak_mag=0, frame_cnt=0, k=0, and running max=0; ready=1 from the first cycle after reset.
REQ-027 rst during SCAN or OUT SHALL abort the frame: no peak_valid and no frame_cnt increment for that frame.
REQ-028 rst has priority over fft_valid in the same cycle; that frame SHALL not be accepted.

Verification
REQ-029 Reset: assert rst 2 cycles -> ready=1, peak_valid=0, peak_idx=0, peak_mag=0, frame_cnt=0, overrun=0.
REQ-030 Single tone: fft_d5={16'sd3,16'sd4}, others 0, fft_valid at t -> peak_valid at t+17, peak_idx=5, peak_mag=25, frame_cnt=1.
REQ-031 Tie and sign: fft_d2=fft_d9={16'sd0,-16'sd10}, others {1,1} -> peak_idx=2, peak_mag=100.
REQ-032 Extreme: fft_d15=32'h8000_8000, others 32'h7FFF_0000 -> peak_idx=15, peak_mag=32'h8000_0000; bins 0..14 each 32'h3FFF_0001.
REQ-033 Overrun: second fft_valid at t+5 with a different frame -> overrun=1 at t+6, first result unchanged at t+17, frame_cnt +1 only; third fft_valid at t+18 accepted.
REQ-034 Mid-scan reset: rst at t+8 -> no peak_valid through t+20, ready=1 at t+9, frame_cnt unchanged; next frame processes normally.
